// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-grant round-robin arbiter in front of a two-port RAM (optional ARB_STATS_EN grant counters)
module ram_port_arbiter #(
    parameter int NUM_CORES      = 4,
    parameter int address_length = 4,
    parameter int word_length    = 64
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_CORES-1:0]                req_valid,
    input  logic [NUM_CORES-1:0]                req_we,
    input  logic [NUM_CORES*address_length-1:0] req_addr,
    input  logic [NUM_CORES*word_length-1:0]    req_wdata,
    output logic [NUM_CORES-1:0]                req_ready,
    output logic [NUM_CORES-1:0]                rsp_valid,
    output logic [word_length-1:0]              rsp_rdata,
    output logic [word_length-1:0]              rsp_rdata_b,
    output logic [address_length-1:0]           address_a,
    output logic [address_length-1:0]           address_b,
    output logic [word_length-1:0]              data_a,
    output logic [word_length-1:0]              data_b,
    output logic                                wren_a,
    output logic                                wren_b,
    input  logic [word_length-1:0]              q_a,
    input  logic [word_length-1:0]              q_b
`ifdef ARB_STATS_EN
    ,
    output logic [NUM_CORES*16-1:0]             stat_grants
`endif
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [PTR_W-1:0]          rr_ptr;
    logic [PTR_W-1:0]          rr_next;
    logic [PTR_W-1:0]          win_a;
    logic [PTR_W-1:0]          win_b;
    logic [PTR_W-1:0]          cand;
    logic [PTR_W-1:0]          last_win;
    logic                      found_a;
    logic                      found_b;
    logic                      hazard;
    logic [NUM_CORES-1:0]      grant_a;
    logic [NUM_CORES-1:0]      grant_b;
    logic [NUM_CORES-1:0]      port_tag;
    logic [PTR_W:0]            next_sum;

    logic [address_length-1:0] addr_arr  [NUM_CORES];
    logic [word_length-1:0]    wdata_arr [NUM_CORES];

    // Unpack the flat per-core payload buses into indexable arrays
    for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*address_length +: address_length];
        assign wdata_arr[g] = req_wdata[g*word_length +: word_length];
    end

    // Core index visited at position 'offset' of the round-robin scan
    function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base,
                                                  input int unsigned      offset);
        logic [PTR_W:0] s;
        s = {1'b0, base} + (PTR_W+1)'(offset);
        if (s >= (PTR_W+1)'(NUM_CORES)) begin
            s = s - (PTR_W+1)'(NUM_CORES);
        end
        return s[PTR_W-1:0];
    endfunction

    // Scan from rr_ptr: first valid core takes port A, next hazard-free valid core takes port B
    always_comb begin
        found_a = 1'b0;
        found_b = 1'b0;
        win_a   = '0;
        win_b   = '0;
        cand    = '0;
        hazard  = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            cand   = rr_index(rr_ptr, k);
            // A same-address pair is only safe when both sides are reads
            hazard = found_a && (addr_arr[cand] == addr_arr[win_a]) &&
                     (req_we[cand] || req_we[win_a]);
            if (req_valid[cand]) begin
                if (!found_a) begin
                    found_a = 1'b1;
                    win_a   = cand;
                end else if (!found_b && !hazard) begin
                    found_b = 1'b1;
                    win_b   = cand;
                end
            end
        end
    end

    // One-hot grant vectors, suppressed entirely while reset is held
    always_comb begin
        grant_a = '0;
        grant_b = '0;
        if (found_a && !reset) begin
            grant_a[win_a] = 1'b1;
        end
        if (found_b && !reset) begin
            grant_b[win_b] = 1'b1;
        end
    end

    assign req_ready = grant_a | grant_b;

    // RAM port drive; an idle port never writes
    always_comb begin
        address_a = '0;
        data_a    = '0;
        wren_a    = 1'b0;
        address_b = '0;
        data_b    = '0;
        wren_b    = 1'b0;
        if (found_a) begin
            address_a = addr_arr[win_a];
            data_a    = wdata_arr[win_a];
            wren_a    = req_we[win_a] && !reset;
        end
        if (found_b) begin
            address_b = addr_arr[win_b];
            data_b    = wdata_arr[win_b];
            wren_b    = req_we[win_b] && !reset;
        end
    end

    // Pointer moves just past the last core granted this cycle
    always_comb begin
        last_win = found_b ? win_b : win_a;
        next_sum = {1'b0, last_win} + (PTR_W+1)'(1);
        if (next_sum >= (PTR_W+1)'(NUM_CORES)) begin
            next_sum = '0;
        end
        rr_next = next_sum[PTR_W-1:0];
    end

    // Round-robin pointer, one-cycle response strobe and per-core port tag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            rsp_valid <= '0;
            port_tag  <= '0;
        end else begin
            rsp_valid <= req_ready;
            if (|req_ready) begin
                rr_ptr <= rr_next;
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (req_ready[i]) begin
                    port_tag[i] <= grant_b[i];
                end
            end
        end
    end

    // Route each RAM port's read data to the bus matching the responding cores' tags
    always_comb begin
        rsp_rdata   = '0;
        rsp_rdata_b = '0;
        if (|(rsp_valid & ~port_tag)) begin
            rsp_rdata = q_a;
        end
        if (|(rsp_valid & port_tag)) begin
            rsp_rdata_b = q_b;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] grant_cnt [NUM_CORES];

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_stats
        // Saturating per-core grant counter
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                grant_cnt[g] <= '0;
            end else if (req_ready[g] && (grant_cnt[g] != 16'hFFFF)) begin
                grant_cnt[g] <= grant_cnt[g] + 16'd1;
            end
        end
        assign stat_grants[g*16 +: 16] = grant_cnt[g];
    end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;

    localparam int NC = 4;
    localparam int AW = 4;
    localparam int DW = 64;

    logic              clk;
    logic              reset;
    logic [NC-1:0]     req_valid;
    logic [NC-1:0]     req_we;
    logic [NC*AW-1:0]  req_addr;
    logic [NC*DW-1:0]  req_wdata;
    logic [NC-1:0]     req_ready;
    logic [NC-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic [DW-1:0]     rsp_rdata_b;
    logic [AW-1:0]     address_a;
    logic [AW-1:0]     address_b;
    logic [DW-1:0]     data_a;
    logic [DW-1:0]     data_b;
    logic              wren_a;
    logic              wren_b;
    logic [DW-1:0]     q_a;
    logic [DW-1:0]     q_b;
`ifdef ARB_STATS_EN
    logic [NC*16-1:0]  stat_grants;
`endif

    logic [DW-1:0]     mem [16];
    logic              ram_load;

    int n_cmp;
    int n_err;
    int pulses [NC];

    ram_port_arbiter #(
        .NUM_CORES      (NC),
        .address_length (AW),
        .word_length    (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_rdata_b (rsp_rdata_b),
        .address_a   (address_a),
        .address_b   (address_b),
        .data_a      (data_a),
        .data_b      (data_b),
        .wren_a      (wren_a),
        .wren_b      (wren_b),
        .q_a         (q_a),
        .q_b         (q_b)
`ifdef ARB_STATS_EN
        ,
        .stat_grants (stat_grants)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-port RAM model with one-cycle registered read data
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= '0;
            end
            mem[0] <= 64'hFEEDFACECAFEBABE;
        end else begin
            if (wren_a) mem[address_a] <= data_a;
            if (wren_b) mem[address_b] <= data_b;
        end
        q_a <= mem[address_a];
        q_b <= mem[address_b];
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic set_req(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[c]           = 1'b1;
        req_we[c]              = we;
        req_addr[c*AW +: AW]   = a;
        req_wdata[c*DW +: DW]  = d;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b1;
        ram_load = 1'b1;
        clear_reqs();
        set_req(0, 1'b1, 4'h3, 64'h0123456789ABCDEF);
        cycle();
        cycle();
        // reset state with a pending write request present
        check_eq("rst_ready", 64'(req_ready), 64'h0);
        check_eq("rst_wren_a", 64'(wren_a), 64'h0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'h0);

        reset    = 1'b0;
        ram_load = 1'b0;
        clear_reqs();
        cycle();

        // single reader, core 2, address 0
        set_req(2, 1'b0, 4'h0, 64'h0);
        #2;
        check_eq("single_ready", 64'(req_ready), 64'h4);
        check_eq("single_addr_a", 64'(address_a), 64'h0);
        check_eq("single_wren_a", 64'(wren_a), 64'h0);
        check_eq("single_wren_b", 64'(wren_b), 64'h0);
        cycle();
        clear_reqs();
        check_eq("single_rsp_valid", 64'(rsp_valid), 64'h4);
        check_eq("single_rdata", rsp_rdata, 64'hFEEDFACECAFEBABE);

        // dual write: rr_ptr=3, scan 3,0,1,2 -> core 0 on A, core 1 on B
        set_req(0, 1'b1, 4'h1, 64'h1111111111111111);
        set_req(1, 1'b1, 4'h2, 64'h2222222222222222);
        #2;
        check_eq("dual_ready", 64'(req_ready), 64'h3);
        check_eq("dual_addr_a", 64'(address_a), 64'h1);
        check_eq("dual_addr_b", 64'(address_b), 64'h2);
        check_eq("dual_wren", 64'({wren_a, wren_b}), 64'h3);
        check_eq("dual_data_b", data_b, 64'h2222222222222222);
        cycle();
        clear_reqs();
        check_eq("dual_rsp_valid", 64'(rsp_valid), 64'h3);

        // readback through core 3
        set_req(3, 1'b0, 4'h1, 64'h0);
        cycle();
        clear_reqs();
        check_eq("rb1_rsp_valid", 64'(rsp_valid), 64'h8);
        check_eq("rb1_rdata", rsp_rdata, 64'h1111111111111111);
        set_req(3, 1'b0, 4'h2, 64'h0);
        cycle();
        clear_reqs();
        check_eq("rb2_rdata", rsp_rdata, 64'h2222222222222222);

        // write hazard on address 5: rr_ptr=0, core 0 wins, core 1 deferred
        set_req(0, 1'b1, 4'h5, 64'hA5A5A5A5A5A5A5A5);
        set_req(1, 1'b1, 4'h5, 64'h5A5A5A5A5A5A5A5A);
        #2;
        check_eq("haz_ready0", 64'(req_ready), 64'h1);
        check_eq("haz_wren_b", 64'(wren_b), 64'h0);
        cycle();
        req_valid[0] = 1'b0;
        req_we[0]    = 1'b0;
        check_eq("haz_rsp0", 64'(rsp_valid), 64'h1);
        #2;
        check_eq("haz_ready1", 64'(req_ready), 64'h2);
        cycle();
        clear_reqs();
        check_eq("haz_rsp1", 64'(rsp_valid), 64'h2);
        set_req(3, 1'b0, 4'h5, 64'h0);
        cycle();
        clear_reqs();
        check_eq("haz_readback", rsp_rdata, 64'h5A5A5A5A5A5A5A5A);

        // fairness: all four cores hold valid for 8 cycles, rr_ptr=0
        for (int c = 0; c < NC; c++) pulses[c] = 0;
        set_req(0, 1'b0, 4'h1, 64'h0);
        set_req(1, 1'b0, 4'h2, 64'h0);
        set_req(2, 1'b0, 4'h5, 64'h0);
        set_req(3, 1'b0, 4'h0, 64'h0);
        for (int k = 0; k < 8; k++) begin
            #2;
            check_eq($sformatf("fair_ready%0d", k), 64'(req_ready),
                     (k % 2 == 0) ? 64'h3 : 64'hC);
            cycle();
            for (int c = 0; c < NC; c++) begin
                if (rsp_valid[c]) pulses[c]++;
            end
        end
        clear_reqs();
        for (int c = 0; c < NC; c++) begin
            check_eq($sformatf("fair_pulses%0d", c), 64'(pulses[c]), 64'd4);
        end

        // reset during a read grant: move rr_ptr to 2 first
        set_req(1, 1'b0, 4'h0, 64'h0);
        cycle();
        clear_reqs();
        set_req(2, 1'b0, 4'h1, 64'h0);
        #1;
        check_eq("rstmid_ready_pre", 64'(req_ready), 64'h4);
        reset = 1'b1;
        #1;
        check_eq("rstmid_ready_rst", 64'(req_ready), 64'h0);
        check_eq("rstmid_rsp_rst", 64'(rsp_valid), 64'h0);
        cycle();
        check_eq("rstmid_rsp_edge", 64'(rsp_valid), 64'h0);
        reset = 1'b0;
        clear_reqs();
        cycle();
        check_eq("rstmid_rsp_after", 64'(rsp_valid), 64'h0);
`ifdef ARB_STATS_EN
        check_eq("stat_after_reset", 64'(stat_grants), 64'h0);
`endif
        // rr_ptr back at 0: scan 0,1,2,3 puts core 1 on A and core 3 on B
        set_req(1, 1'b0, 4'h1, 64'h0);
        set_req(3, 1'b0, 4'h2, 64'h0);
        #2;
        check_eq("rstmid_ready_post", 64'(req_ready), 64'hA);
        check_eq("rstmid_addr_a", 64'(address_a), 64'h1);
        check_eq("rstmid_addr_b", 64'(address_b), 64'h2);
        cycle();
        clear_reqs();
        check_eq("rstmid_rsp_post", 64'(rsp_valid), 64'hA);
        check_eq("rstmid_rdata_a", rsp_rdata, 64'h1111111111111111);
        check_eq("rstmid_rdata_b", rsp_rdata_b, 64'h2222222222222222);

`ifdef ARB_STATS_EN
        check_eq("stat_core1", 64'(stat_grants[31:16]), 64'h1);
        set_req(0, 1'b0, 4'h0, 64'h0);
        repeat (70000) cycle();
        clear_reqs();
        cycle();
        check_eq("stat_saturate", 64'(stat_grants[15:0]), 64'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
